// File: rtl/pipe_bar_elastic.sv
// Elastic pipeline barrier: two-entry skid buffer with flush, hold and a registered in_ready.
// Optional performance counters (stall_cnt, flush_cnt) are built when BAR_PERF_CNT_EN is defined.
module pipe_bar_elastic #(
  parameter int DATA_W = 138,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              step_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              hold,
`ifdef BAR_PERF_CNT_EN
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`else
  output logic [1:0]        occupancy
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_ready_r;
  logic              freeze;
  logic              in_fire, out_fire;

  // flush outranks hold, so a frozen barrier can still be squashed
  assign freeze    = hold & ~flush;
  assign in_ready  = in_ready_r & ~freeze;
  assign out_valid = (state != EMPTY) & ~freeze;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge step_clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_r <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      in_ready_r <= 1'b1;
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              skid_data  <= in_data;
              skid_ctrl  <= in_ctrl;
              state      <= FULL;
              in_ready_r <= 1'b0;
            end
            2'b01: state <= EMPTY;
            2'b11: begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end
            default: ;
          endcase
        end
        FULL: begin
          // in_ready is low here, so only a drain can move the state
          if (out_fire) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= ONE;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef BAR_PERF_CNT_EN
  always_ff @(posedge step_clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && state != EMPTY && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_bar_elastic.sv
// Bench for pipe_bar_elastic: directed scenarios plus random traffic checked against a queue model.
// Counter checks are compiled in when BAR_PERF_CNT_EN is defined.
module tb_pipe_bar_elastic;

  localparam int DATA_W = 138;
  localparam int CTRL_W = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  logic              step_clk, reset;
  logic              in_valid, in_ready, out_valid, out_ready, flush, hold;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipe_bar_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .step_clk (step_clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .flush    (flush),
    .hold     (hold),
`ifdef BAR_PERF_CNT_EN
    .occupancy(occupancy),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`else
    .occupancy(occupancy)
`endif
  );

`ifndef BAR_PERF_CNT_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  initial begin
    step_clk = 1'b0;
    forever #5 step_clk = ~step_clk;
  end

  int checks = 0;
  int errors = 0;

  // reference model: FIFO of held beats plus the few registered observables
  beat_t             q[$];
  logic              m_in_ready;
  logic [DATA_W-1:0] m_last;
  int                m_stall, m_flush;

  task automatic check_output(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_in_ready = 1'b0;
    m_last     = '0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic apply_stimulus(input logic iv, input logic [DATA_W-1:0] id, input logic [CTRL_W-1:0] ic,
                                input logic ordy, input logic fl, input logic hd);
    logic hold_eff, exp_ir, exp_ov, in_fire, out_fire;
    logic [DATA_W-1:0] exp_d;
    logic [CTRL_W-1:0] exp_c;
    @(negedge step_clk);
    in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy; flush = fl; hold = hd;
    #1;
    hold_eff = hd & ~fl;
    exp_ir   = m_in_ready & ~hold_eff;
    exp_ov   = (q.size() > 0) & ~hold_eff;
    exp_d    = (q.size() > 0) ? q[0].d : m_last;
    exp_c    = (exp_ov && q.size() > 0) ? q[0].c : '0;
    check_output("in_ready", 256'(in_ready), 256'(exp_ir));
    check_output("out_valid", 256'(out_valid), 256'(exp_ov));
    check_output("out_data", 256'(out_data), 256'(exp_d));
    check_output("out_ctrl", 256'(out_ctrl), 256'(exp_c));
    check_output("occupancy", 256'(occupancy), 256'(q.size()));
`ifdef BAR_PERF_CNT_EN
    check_output("stall_cnt", 256'(stall_cnt), 256'(m_stall));
    check_output("flush_cnt", 256'(flush_cnt), 256'(m_flush));
`endif
    in_fire  = iv & exp_ir;
    out_fire = exp_ov & ordy;
    @(posedge step_clk);
    if (exp_ov && !ordy && m_stall < (1 << CNT_W) - 1) m_stall++;
    if (fl) begin
      if (q.size() > 0 && m_flush < (1 << CNT_W) - 1) m_flush++;
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back('{c: ic, d: id});
    end
    if (q.size() > 0) m_last = q[0].d;
    m_in_ready = (q.size() != 2);
  endtask

  task automatic idle(input logic ordy);
    apply_stimulus(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge step_clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_output("rst_in_ready", 256'(in_ready), 256'(0));
    check_output("rst_out_valid", 256'(out_valid), 256'(0));
    check_output("rst_out_data", 256'(out_data), 256'(0));
    check_output("rst_out_ctrl", 256'(out_ctrl), 256'(0));
    check_output("rst_occupancy", 256'(occupancy), 256'(0));
    @(negedge step_clk);
    reset = 1'b0;
    #1;
    check_output("rel_in_ready", 256'(in_ready), 256'(0));
    @(posedge step_clk);
    m_in_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
    model_reset();

    // fill and drain
    apply_reset();
    apply_stimulus(1'b1, DATA_W'(1), 5'h11, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, DATA_W'(2), 5'h12, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_output("fill_occupancy", 256'(occupancy), 256'(2));
    check_output("fill_in_ready", 256'(in_ready), 256'(0));
    idle(1'b1);
    check_output("drain_first", 256'(out_data), 256'(1));
    idle(1'b1);
    check_output("drain_second", 256'(out_data), 256'(2));
    idle(1'b1);
    check_output("drain_empty", 256'(out_valid), 256'(0));

    // streaming, one beat per cycle
    for (int i = 0; i < 16; i++)
      apply_stimulus(1'b1, DATA_W'(8'h10 + i), CTRL_W'(i), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check_output("stream_last", 256'(out_data), 256'(8'h1F));
    idle(1'b1);

    // flush while full with a competing beat
    apply_reset();
    apply_stimulus(1'b1, DATA_W'(8'hA1), 5'h1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, DATA_W'(8'hA2), 5'h2, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, DATA_W'(3), 5'h3, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check_output("flush_occupancy", 256'(occupancy), 256'(0));
    check_output("flush_out_ctrl", 256'(out_ctrl), 256'(0));
    check_output("flush_in_ready", 256'(in_ready), 256'(1));
`ifdef BAR_PERF_CNT_EN
    check_output("flush_cnt_one", 256'(flush_cnt), 256'(1));
`endif
    idle(1'b1);

    // hold for three cycles in ONE
    apply_stimulus(1'b1, DATA_W'(5), 5'h5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DATA_W'(9), 5'h9, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_output("hold_release", 256'(out_data), 256'(5));
    idle(1'b1);

    // stall saturation
    apply_reset();
    apply_stimulus(1'b1, DATA_W'(7), 5'h7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
`ifdef BAR_PERF_CNT_EN
    check_output("stall_sat", 256'(stall_cnt), 256'(15));
`endif

    // asynchronous reset pulse while full
    apply_stimulus(1'b1, DATA_W'(8), 5'h8, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge step_clk);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_output("areset_out_valid", 256'(out_valid), 256'(0));
    check_output("areset_occupancy", 256'(occupancy), 256'(0));
    reset = 1'b0;
    model_reset();
    @(posedge step_clk);
    m_in_ready = 1'b1;
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      apply_stimulus(($urandom_range(0, 9) < 7), rand_data(), CTRL_W'($urandom),
                     ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 9) == 0));
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_bar_elastic.md
PIPE_BAR_ELASTIC -- requirements
Module: pipe_bar_elastic

Interface
REQ-001 The block SHALL have parameter DATA_W, default 138, giving the payload width (branch_target 64 + alu_result 32 + alu_zero 1 + read_data2 32 + write_reg 4 + wb 2 + m 3).
REQ-002 The block SHALL have parameter CTRL_W, default 5, giving the control-bundle width (wb and m fields); the control bundle is zeroed on bubbles.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the performance counters.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports, one per line: name  direction  width  meaning.
- step_clk  in  1  pipeline step clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream stage presents a beat.
- in_ready  out  1  barrier accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  barrier presents a beat downstream.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  payload to the next stage.
- out_ctrl  out  CTRL_W  control to the next stage; all zero whenever out_valid=0.
- flush  in  1  synchronous squash of all held beats (mispredict or trap).
- hold  in  1  freezes the barrier with no transfers.
- occupancy  out  2  number of held beats (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (BAR_PERF_CNT_EN only).
- flush_cnt  out  CNT_W  flushes that discarded at least one beat (BAR_PERF_CNT_EN only).

Function
REQ-006 Handshake rules:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Payload and control SHALL be captured only on in_fire.
REQ-007 Storage SHALL be a two-entry skid buffer: a main register drives the outputs, and a skid register sits behind it.
REQ-008 The FSM SHALL have states EMPTY, ONE and FULL, with occupancy = 0, 1 and 2 respectively.
REQ-009 EMPTY transitions: on in_fire, load main and go to ONE; otherwise stay in EMPTY.
REQ-010 ONE transitions:
- in_fire only: load skid, go to FULL.
- out_fire only: go to EMPTY.
- in_fire and out_fire together: load main with the new beat, stay in ONE.
REQ-011 FULL transitions: on out_fire, move skid to main and go to ONE; in_ready SHALL be 0 in FULL.
REQ-012 in_ready SHALL be a registered signal equal to (next state != FULL) and SHALL NOT depend combinationally on out_ready.
REQ-013 Latency from in_fire in EMPTY to out_valid=1 SHALL be exactly 1 cycle; throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-014 Beats SHALL leave in arrival order; no beat is lost or duplicated except by flush.
REQ-015 flush SHALL have the highest priority:
- Next state is EMPTY.
- An in_fire in the same cycle is discarded.
- out_valid=0 and out_ctrl=0 the following cycle.
- in_ready=1 the following cycle.
REQ-016 While hold=1 and flush=0:
- in_ready and out_valid SHALL be driven 0 combinationally.
- The state and both registers SHALL be unchanged.
- out_ctrl SHALL be 0.
REQ-017 out_data SHALL keep its last value while out_valid=0.

Reset
REQ-018 On reset, the FSM SHALL go to EMPTY, and out_valid, out_data, out_ctrl and occupancy SHALL be 0.
REQ-019 On reset, in_ready SHALL be 0 while reset is asserted and 1 on the first clock after release.
REQ-020 On reset, both counters SHALL be 0.
REQ-021 Reset asserted mid-transfer SHALL discard all held beats immediately, without waiting for a clock edge.

Configuration
REQ-022 Macro BAR_PERF_CNT_EN when defined:
- stall_cnt and flush_cnt exist.
- Each saturates at 2^CNT_W-1 and does not wrap.
- Each increments at most once per cycle.
- flush_cnt increments when flush=1 with occupancy>0.
REQ-023 Macro BAR_PERF_CNT_EN when undefined: the stall_cnt and flush_cnt ports and the counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 Fill and drain: reset, out_ready=0, push A=0x1, B=0x2 -> occupancy=2 and in_ready=0 next cycle; then out_ready=1 -> out_data is 0x1 then 0x2 on consecutive cycles, then out_valid=0.
REQ-025 Streaming: out_ready=1, push 0x10..0x1F back-to-back -> each beat appears 1 cycle later, 16 beats in 17 cycles, occupancy never exceeds 1.
REQ-026 Flush while FULL with in_valid=1 (beat 0x3) -> next cycle occupancy=0, out_ctrl=0, 0x3 never appears; flush_cnt=1 with BAR_PERF_CNT_EN.
REQ-027 hold=1 for 3 cycles in state ONE (beat 0x5, out_ready=1) -> out_valid=0 and in_ready=0 throughout; 0x5 is delivered on the first cycle after hold drops.
REQ-028 Saturation with CNT_W=4 and BAR_PERF_CNT_EN: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays there.
REQ-029 Asynchronous reset pulse between clock edges while occupancy=2 -> out_valid=0 and occupancy=0 before the next edge; in_ready=1 on the first edge after release.
